i2c_addr_xlate: RTL and testbench
=================================

I2C_ADDR_XLATE -- requirements
Module: i2c_addr_xlate

Interface
REQ-001 Parameter NUM_MAP, default 4: number of translation entries (power of 2).
REQ-002 Parameter MAX_RETRY, default 2: number of re-issues after a NACK.
REQ-003 Parameter TIMEOUT_CYC, default 20000: clk cycles to wait for done before abort.
REQ-004 clk  in  1  system clock; one clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cfg_we  in  1  table write strobe.
REQ-007 cfg_idx  in  log2(NUM_MAP)  entry index.
REQ-008 cfg_en  in  1  entry valid bit to write.
REQ-009 cfg_virt  in  7  virtual (host-visible) address.
REQ-010 cfg_phys  in  7  physical bus address.
REQ-011 req_valid  in  1  host request valid.
REQ-012 req_ready  out  1  block accepts a request.
REQ-013 req_addr  in  7  virtual target address.
REQ-014 req_rw  in  1  0 = write, 1 = read.
REQ-015 req_data  in  8  write data byte.
REQ-016 rsp_valid  out  1  one-cycle completion pulse.
REQ-017 rsp_status  out  2  00 OK, 01 NACK, 10 no mapping, 11 timeout.
REQ-018 rsp_retries  out  2  re-issues used.
REQ-019 start_req  out  1  to i2c_master, one-cycle pulse.
REQ-020 slave_addr  out  7  to i2c_master, translated address.
REQ-021 rw_bit  out  1  to i2c_master.
REQ-022 data_in  out  8  to i2c_master.
REQ-023 busy  in  1  from i2c_master.
REQ-024 ack_error  in  1  from i2c_master, sampled only with done.
REQ-025 done  in  1  from i2c_master, one-cycle completion pulse.

Function
REQ-026 FSM states: IDLE, LOOKUP, ISSUE, WAIT_DONE, RESP.
REQ-027 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid & req_ready, latching req_addr, req_rw and req_data, and the FSM moves to LOOKUP.
REQ-028 LOOKUP (1 cycle): select the lowest-index entry with en=1 and virt==latched addr; on a hit latch phys and go to ISSUE; on a miss go to RESP with status 10, with start_req never asserted.
REQ-029 ISSUE (1 cycle): start_req=1; slave_addr/rw_bit/data_in SHALL be driven from latched values and held stable from ISSUE until leaving WAIT_DONE.
REQ-030 WAIT_DONE: the timeout counter is cleared on ISSUE and incremented each cycle.
REQ-031 WAIT_DONE exit on done: if ack_error=0 -> RESP with status 00; else if retries<MAX_RETRY -> increment retries and go to ISSUE; else -> RESP with status 01.
REQ-032 WAIT_DONE timeout: if the counter reaches TIMEOUT_CYC-1 without done -> RESP with status 11.
REQ-033 If done and the timeout are reached in the same cycle, done SHALL take priority.
REQ-034 RESP (1 cycle): rsp_valid=1 with rsp_status and rsp_retries valid; the next state is IDLE.
REQ-035 Request-to-start latency SHALL be exactly 2 cycles after acceptance; done-to-rsp_valid latency SHALL be 1 cycle.
REQ-036 A table write takes effect the cycle after cfg_we; a write in the same cycle as LOOKUP SHALL be seen by the lookup as the old value.
REQ-037 A table write during an active transaction SHALL NOT change the latched slave_addr.
REQ-038 done or ack_error arriving outside WAIT_DONE SHALL be ignored.
REQ-039 The retry counter SHALL saturate and never wrap; the timeout counter width is clog2(TIMEOUT_CYC).

Reset
REQ-040 On rst: state=IDLE, table en bits=0, counters=0.
REQ-041 On rst, outputs: req_ready=0 during rst and 1 the cycle after; start_req=0, rsp_valid=0, rsp_status=00, rsp_retries=0, slave_addr=0, rw_bit=0, data_in=0.
REQ-042 rst asserted mid-transaction SHALL abort it without a rsp_valid pulse; the i2c_master is reset by the same rst.

Structure
REQ-043 Package i2c_xlat_pkg SHALL hold the state enum, the rsp_status codes (ST_OK, ST_NACK, ST_NOMAP, ST_TIMEOUT) and the map-entry struct {en, virt, phys}.
REQ-044 Sub-module i2c_xlat_table SHALL hold the NUM_MAP-entry register file, the write port and the priority match logic (hit, phys).
REQ-045 The top level SHALL contain only the FSM, the latches and the counters.

Verification
REQ-046 Map entry 0 as 0x10->0x34 in i2c_master+i2c_slave(0x34) bench; request write 0x10 with data 0xAA -> slave_addr=0x34, start_req exactly 2 cycles after accept, rsp_status=00, rsp_retries=0.
REQ-047 Request to 0x22 with an empty table -> rsp_valid 2 cycles after accept, status 10, start_req never asserted.
REQ-048 Map 0x11->0x50 with no slave at 0x50, MAX_RETRY=2 -> 3 start_req pulses, status 01, rsp_retries=2.
REQ-049 Entries 1 and 3 both map virt 0x10 (phys 0x34 and 0x35) -> slave_addr=0x34; with TIMEOUT_CYC=50 and done tied low -> status 11 exactly 50 cycles after ISSUE.
REQ-050 Assert rst during WAIT_DONE -> no rsp_valid pulse, all outputs at reset values the next cycle; a cfg_we rewriting the active entry mid-transfer leaves slave_addr unchanged.

Source files
------------

// File: rtl/i2c_addr_xlate_pkg.sv
// i2c_xlat_pkg: shared types for the I2C address translator.
//   state_e      - translator FSM states
//   status_t     - rsp_status encoding (ST_OK / ST_NACK / ST_NOMAP / ST_TIMEOUT)
//   map_entry_t  - one translation-table entry {en, virt, phys}
//   sat_inc2     - saturating increment for the 2-bit retry counter
package i2c_xlat_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        ISSUE,
        WAIT_DONE,
        RESP
    } state_e;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK      = 2'b00;
    localparam status_t ST_NACK    = 2'b01;
    localparam status_t ST_NOMAP   = 2'b10;
    localparam status_t ST_TIMEOUT = 2'b11;

    typedef struct packed {
        logic       en;
        logic [6:0] virt;
        logic [6:0] phys;
    } map_entry_t;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/i2c_addr_xlate_if.sv
// i2c_addr_xlate_if: host-side request/response handshake of the translator.
//   req_valid/req_ready/req_addr/req_rw/req_data - request channel
//   rsp_valid/rsp_status/rsp_retries            - one-cycle completion report
//   modport slave  - used by the translator
//   modport master - used by the host
interface i2c_addr_xlate_if;
    import i2c_xlat_pkg::*;

    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic       req_rw;
    logic [7:0] req_data;
    logic       rsp_valid;
    status_t    rsp_status;
    logic [1:0] rsp_retries;

    modport slave (
        input  req_valid, req_addr, req_rw, req_data,
        output req_ready, rsp_valid, rsp_status, rsp_retries
    );

    modport master (
        output req_valid, req_addr, req_rw, req_data,
        input  req_ready, rsp_valid, rsp_status, rsp_retries
    );

endinterface

// File: rtl/i2c_addr_xlate_table.sv
// i2c_xlat_table: NUM_MAP-entry virtual->physical address map.
//   clk, rst                         - clock, sync active-high reset (clears all entries)
//   cfg_we/cfg_idx/cfg_en/cfg_virt/cfg_phys - write port, visible the cycle after cfg_we
//   lookup_addr                      - virtual address to translate
//   hit, hit_phys                    - lowest-index enabled match and its physical address
module i2c_xlat_table
    import i2c_xlat_pkg::*;
#(
    parameter int NUM_MAP = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_MAP)-1:0] cfg_idx,
    input  logic                       cfg_en,
    input  logic [6:0]                 cfg_virt,
    input  logic [6:0]                 cfg_phys,
    input  logic [6:0]                 lookup_addr,
    output logic                       hit,
    output logic [6:0]                 hit_phys
);

    map_entry_t tbl_q [NUM_MAP];
    map_entry_t tbl_d [NUM_MAP];

    always_comb begin
        tbl_d = tbl_q;
        if (cfg_we) begin
            tbl_d[cfg_idx] = '{en: cfg_en, virt: cfg_virt, phys: cfg_phys};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_q <= '{default: '0};
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // Match against the registered table only, so a write in the lookup
    // cycle is not seen. Scanning downward lets the lowest index win.
    always_comb begin
        hit      = 1'b0;
        hit_phys = '0;
        for (int i = NUM_MAP - 1; i >= 0; i--) begin
            if (tbl_q[i].en && (tbl_q[i].virt == lookup_addr)) begin
                hit      = 1'b1;
                hit_phys = tbl_q[i].phys;
            end
        end
    end

endmodule

// File: rtl/i2c_addr_xlate.sv
// i2c_addr_xlate: translates host virtual I2C addresses to physical bus
// addresses and sequences the transfer on an i2c_master, with NACK retry
// and a done timeout.
//   clk, rst      - clock, sync active-high reset
//   cfg_*         - translation table write port
//   host          - request/response handshake (i2c_addr_xlate_if.slave)
//   start_req, slave_addr, rw_bit, data_in - command to i2c_master
//   busy, ack_error, done                 - status from i2c_master
module i2c_addr_xlate
    import i2c_xlat_pkg::*;
#(
    parameter int NUM_MAP     = 4,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_MAP)-1:0] cfg_idx,
    input  logic                       cfg_en,
    input  logic [6:0]                 cfg_virt,
    input  logic [6:0]                 cfg_phys,
    i2c_addr_xlate_if.slave            host,
    output logic                       start_req,
    output logic [6:0]                 slave_addr,
    output logic                       rw_bit,
    output logic [7:0]                 data_in,
    input  logic                       busy,
    input  logic                       ack_error,
    input  logic                       done
);

    localparam int             CW      = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYC - 1);
    // The retry counter is 2 bits wide; a larger limit behaves as 3.
    localparam logic [1:0]     MAX_R   = (MAX_RETRY > 3) ? 2'd3 : 2'(MAX_RETRY);

    state_e        state_q,      state_d;
    logic [6:0]    addr_q,       addr_d;
    logic          rw_q,         rw_d;
    logic [7:0]    data_q,       data_d;
    logic [6:0]    slave_addr_q, slave_addr_d;
    logic [1:0]    retries_q,    retries_d;
    status_t       status_q,     status_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic          start_req_q,  start_req_d;
    logic          rsp_valid_q,  rsp_valid_d;
    logic          req_ready_q,  req_ready_d;

    logic          hit;
    logic [6:0]    hit_phys;

    // busy carries no information the FSM needs beyond done.
    logic unused_busy;
    assign unused_busy = busy;

    i2c_xlat_table #(.NUM_MAP(NUM_MAP)) u_table (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_en      (cfg_en),
        .cfg_virt    (cfg_virt),
        .cfg_phys    (cfg_phys),
        .lookup_addr (addr_q),
        .hit         (hit),
        .hit_phys    (hit_phys)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        data_d       = data_q;
        slave_addr_d = slave_addr_q;
        retries_d    = retries_q;
        status_d     = status_q;
        cnt_d        = cnt_q;
        start_req_d  = 1'b0;
        rsp_valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (host.req_valid && req_ready_q) begin
                    addr_d    = host.req_addr;
                    rw_d      = host.req_rw;
                    data_d    = host.req_data;
                    retries_d = 2'd0;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    slave_addr_d = hit_phys;
                    start_req_d  = 1'b1;
                    cnt_d        = '0;
                    state_d      = ISSUE;
                end else begin
                    status_d    = ST_NOMAP;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            ISSUE: begin
                // Counter starts at 0 in ISSUE, so reaching TO_LAST puts
                // the response exactly TIMEOUT_CYC cycles after ISSUE.
                cnt_d   = cnt_q + CW'(1);
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + CW'(1);
                // done is tested first so it wins over a coincident timeout.
                if (done) begin
                    if (!ack_error) begin
                        status_d    = ST_OK;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else if (retries_q < MAX_R) begin
                        retries_d   = sat_inc2(retries_q);
                        start_req_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ISSUE;
                    end else begin
                        status_d    = ST_NACK;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end else if (cnt_q == TO_LAST) begin
                    status_d    = ST_TIMEOUT;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            data_q       <= '0;
            slave_addr_q <= '0;
            retries_q    <= '0;
            status_q     <= ST_OK;
            cnt_q        <= '0;
            start_req_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            data_q       <= data_d;
            slave_addr_q <= slave_addr_d;
            retries_q    <= retries_d;
            status_q     <= status_d;
            cnt_q        <= cnt_d;
            start_req_q  <= start_req_d;
            rsp_valid_q  <= rsp_valid_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign host.req_ready   = req_ready_q;
    assign host.rsp_valid   = rsp_valid_q;
    assign host.rsp_status  = status_q;
    assign host.rsp_retries = retries_q;
    assign start_req        = start_req_q;
    assign slave_addr       = slave_addr_q;
    assign rw_bit           = rw_q;
    assign data_in          = data_q;

endmodule

// File: tb/tb_i2c_addr_xlate.sv
// Bench for i2c_addr_xlate: behavioural i2c_master/slave stub (slaves at
// 0x34 and 0x35), table-driven vectors, hand sequences for reset and table
// write corner cases, and randomized transactions against a reference model.
module tb_i2c_addr_xlate;

    localparam int TO   = 50;
    localparam int MAXR = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic       cfg_en;
    logic [6:0] cfg_virt;
    logic [6:0] cfg_phys;
    logic       start_req;
    logic [6:0] slave_addr;
    logic       rw_bit;
    logic [7:0] data_in;
    logic       busy;
    logic       ack_error;
    logic       done;

    logic stub_done, stub_ack, frc_done, frc_ack;
    bit   stub_mute;
    int   stub_lat;
    bit   pend;
    int   cd;
    logic [6:0] sent;

    assign done      = stub_done | frc_done;
    assign ack_error = stub_ack  | frc_ack;

    i2c_addr_xlate_if bus();

    i2c_addr_xlate #(.NUM_MAP(4), .MAX_RETRY(MAXR), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_en     (cfg_en),
        .cfg_virt   (cfg_virt),
        .cfg_phys   (cfg_phys),
        .host       (bus),
        .start_req  (start_req),
        .slave_addr (slave_addr),
        .rw_bit     (rw_bit),
        .data_in    (data_in),
        .busy       (busy),
        .ack_error  (ack_error),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         st;
        int         rt;
        int         starts;
        int         first;
        int         rsp_at;
        logic [6:0] sa;
        bit         stable;
    } res_t;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
        bit         mute;
        int         lat;
        int         e_st;
        int         e_rt;
        int         e_starts;
        int         e_rsp;
        logic [6:0] e_sa;
    } vec_t;

    vec_t vecs [7];

    // Reference view of the table and the bus population.
    logic       m_en   [4];
    logic [6:0] m_virt [4];
    logic [6:0] m_phys [4];

    // i2c_master + slave stub: done arrives stub_lat cycles after start_req,
    // NACK unless a slave lives at the addressed location.
    always @(negedge clk) begin
        if (rst) begin
            pend      = 1'b0;
            stub_done = 1'b0;
            stub_ack  = 1'b0;
            busy      = 1'b0;
        end else begin
            stub_done = 1'b0;
            stub_ack  = 1'b0;
            if (pend) begin
                cd = cd - 1;
                if (cd == 0) begin
                    pend      = 1'b0;
                    busy      = 1'b0;
                    stub_done = 1'b1;
                    stub_ack  = !(sent == 7'h34 || sent == 7'h35);
                end
            end
            if (start_req && !stub_mute) begin
                pend = 1'b1;
                cd   = stub_lat;
                sent = slave_addr;
                busy = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_res(input string tag, input res_t r, input res_t e);
        chk({tag, ".status"},  r.st,     e.st);
        chk({tag, ".retries"}, r.rt,     e.rt);
        chk({tag, ".starts"},  r.starts, e.starts);
        chk({tag, ".start_lat"}, r.first, e.first);
        chk({tag, ".rsp_lat"}, r.rsp_at, e.rsp_at);
        chk({tag, ".slave_addr"}, int'(r.sa), int'(e.sa));
        chk({tag, ".stable"},  int'(r.stable), int'(e.stable));
    endtask

    function automatic res_t model(input logic [6:0] a, input bit mute, input int lat);
        res_t e;
        int   hit = -1;
        for (int i = 0; i < 4; i++) begin
            if (hit < 0 && m_en[i] && m_virt[i] == a) hit = i;
        end
        e.stable = 1'b1;
        e.sa     = 7'h00;
        e.rt     = 0;
        if (hit < 0) begin
            e.st = 2; e.starts = 0; e.first = -1; e.rsp_at = 2;
        end else begin
            e.sa    = m_phys[hit];
            e.first = 2;
            if (mute) begin
                e.st = 3; e.starts = 1; e.rsp_at = 2 + TO;
            end else if (e.sa == 7'h34 || e.sa == 7'h35) begin
                e.st = 0; e.starts = 1; e.rsp_at = 2 + (lat + 1);
            end else begin
                e.st = 1; e.rt = MAXR; e.starts = MAXR + 1;
                e.rsp_at = 2 + (MAXR + 1) * (lat + 1);
            end
        end
        return e;
    endfunction

    task automatic cfg_wr(input int idx, input logic en, input logic [6:0] v, input logic [6:0] p);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_en = en; cfg_virt = v; cfg_phys = p;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        m_en[idx] = en; m_virt[idx] = v; m_phys[idx] = p;
    endtask

    // One host transaction. wr_at >= 1 rewrites entry 1 (virt 0x10) in the
    // cycle wr_at cycles after acceptance.
    task automatic run_txn(input logic [6:0] a, input logic rw, input logic [7:0] d,
                           input bit mute, input int lat, input int wr_at,
                           input logic [6:0] wr_phys, output res_t r);
        int n;
        bit got;
        stub_mute = mute;
        stub_lat  = lat;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1; bus.req_addr = a; bus.req_rw = rw; bus.req_data = d;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0; got = 1'b0;
        r.st = -1; r.rt = -1; r.starts = 0; r.first = -1; r.rsp_at = -1;
        r.sa = 7'h00; r.stable = 1'b1;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (start_req) begin
                r.starts++;
                if (r.first < 0) begin
                    r.first = n;
                    r.sa    = slave_addr;
                end
            end
            if (r.first >= 0 && !bus.rsp_valid) begin
                if (slave_addr != r.sa || rw_bit != rw || data_in != d) r.stable = 1'b0;
            end
            if (bus.rsp_valid) begin
                got      = 1'b1;
                r.st     = int'(bus.rsp_status);
                r.rt     = int'(bus.rsp_retries);
                r.rsp_at = n;
            end
            if (n == wr_at) begin
                cfg_we = 1'b1; cfg_idx = 2'd1; cfg_en = 1'b1;
                cfg_virt = 7'h10; cfg_phys = wr_phys;
            end else if (n == wr_at + 1) begin
                cfg_we = 1'b0;
            end
        end
        cfg_we = 1'b0;
    endtask

    task automatic load_base_table();
        cfg_wr(0, 1'b1, 7'h11, 7'h50);
        cfg_wr(1, 1'b1, 7'h10, 7'h34);
        cfg_wr(2, 1'b0, 7'h22, 7'h35);
        cfg_wr(3, 1'b1, 7'h10, 7'h35);
    endtask

    initial begin
        res_t r, e;
        int   nrsp, nstart;
        logic [6:0] a;

        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_virt = '0; cfg_phys = '0;
        frc_done = 1'b0; frc_ack = 1'b0; stub_mute = 1'b0; stub_lat = 1;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_rw = 1'b0; bus.req_data = '0;
        for (int i = 0; i < 4; i++) begin
            m_en[i] = 1'b0; m_virt[i] = '0; m_phys[i] = '0;
        end

        //                addr   rw    data   mute lat  st rt starts rsp  sa
        vecs[0] = '{7'h10, 1'b0, 8'hAA, 1'b0, 3,   0, 0, 1, 6,  7'h34};
        vecs[1] = '{7'h11, 1'b1, 8'h00, 1'b0, 2,   1, 2, 3, 11, 7'h50};
        vecs[2] = '{7'h22, 1'b0, 8'h5A, 1'b0, 1,   2, 0, 0, 2,  7'h00};
        vecs[3] = '{7'h10, 1'b1, 8'h0F, 1'b1, 1,   3, 0, 1, 52, 7'h34};
        vecs[4] = '{7'h10, 1'b0, 8'h3C, 1'b0, 49,  0, 0, 1, 52, 7'h34};
        vecs[5] = '{7'h11, 1'b0, 8'h01, 1'b0, 1,   1, 2, 3, 8,  7'h50};
        vecs[6] = '{7'h33, 1'b1, 8'hFF, 1'b0, 1,   2, 0, 0, 2,  7'h00};

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.req_ready",  int'(bus.req_ready), 0);
        chk("rst.start_req",  int'(start_req), 0);
        chk("rst.rsp_valid",  int'(bus.rsp_valid), 0);
        chk("rst.rsp_status", int'(bus.rsp_status), 0);
        chk("rst.rsp_retries", int'(bus.rsp_retries), 0);
        chk("rst.slave_addr", int'(slave_addr), 0);
        chk("rst.rw_bit",     int'(rw_bit), 0);
        chk("rst.data_in",    int'(data_in), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.req_ready_after", int'(bus.req_ready), 1);

        // Empty table: no mapping, no start.
        run_txn(7'h22, 1'b0, 8'h12, 1'b0, 1, -1, 7'h00, r);
        chk_res("empty", r, model(7'h22, 1'b0, 1));

        // Stray done/ack_error in IDLE is ignored.
        @(negedge clk);
        frc_done = 1'b1; frc_ack = 1'b1;
        @(negedge clk);
        frc_done = 1'b0; frc_ack = 1'b0;
        nrsp = 0; nstart = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid) nrsp++;
            if (start_req) nstart++;
        end
        chk("stray.rsp_valid", nrsp, 0);
        chk("stray.start_req", nstart, 0);
        chk("stray.req_ready", int'(bus.req_ready), 1);

        // Fixed vectors.
        load_base_table();
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].addr, vecs[i].rw, vecs[i].data, vecs[i].mute, vecs[i].lat, -1, 7'h00, r);
            e.st = vecs[i].e_st; e.rt = vecs[i].e_rt; e.starts = vecs[i].e_starts;
            e.first = (vecs[i].e_starts > 0) ? 2 : -1;
            e.rsp_at = vecs[i].e_rsp; e.sa = vecs[i].e_sa; e.stable = 1'b1;
            chk_res($sformatf("vec%0d", i), r, e);
        end

        // Rewrite of the active entry mid-transfer keeps slave_addr.
        run_txn(7'h10, 1'b0, 8'h77, 1'b0, 8, 5, 7'h35, r);
        chk_res("midwr", r, model(7'h10, 1'b0, 8));
        m_phys[1] = 7'h35;
        run_txn(7'h10, 1'b1, 8'h00, 1'b0, 2, -1, 7'h00, r);
        chk("midwr.after", int'(r.sa), 32'h35);

        // Write landing in the LOOKUP cycle is not seen by that lookup.
        run_txn(7'h10, 1'b0, 8'h44, 1'b0, 2, 1, 7'h34, r);
        chk_res("lkwr", r, model(7'h10, 1'b0, 2));
        m_phys[1] = 7'h34;
        run_txn(7'h10, 1'b0, 8'h45, 1'b0, 2, -1, 7'h00, r);
        chk("lkwr.after", int'(r.sa), 32'h34);

        // Reset during WAIT_DONE aborts silently.
        stub_mute = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = 7'h10; bus.req_rw = 1'b1; bus.req_data = 8'hC3;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("rstmid.pre_slave", int'(slave_addr), 32'h34);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid.req_ready",  int'(bus.req_ready), 0);
        chk("rstmid.rsp_valid",  int'(bus.rsp_valid), 0);
        chk("rstmid.start_req",  int'(start_req), 0);
        chk("rstmid.slave_addr", int'(slave_addr), 0);
        chk("rstmid.rw_bit",     int'(rw_bit), 0);
        chk("rstmid.data_in",    int'(data_in), 0);
        chk("rstmid.retries",    int'(bus.rsp_retries), 0);
        rst = 1'b0;
        nrsp = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) nrsp++;
        end
        chk("rstmid.no_rsp", nrsp, 0);
        chk("rstmid.ready_after", int'(bus.req_ready), 1);
        for (int i = 0; i < 4; i++) m_en[i] = 1'b0;
        run_txn(7'h10, 1'b0, 8'h01, 1'b0, 1, -1, 7'h00, r);
        chk_res("rstmid.cleared", r, model(7'h10, 1'b0, 1));

        // Randomized transactions against the model.
        load_base_table();
        for (int t = 0; t < 30; t++) begin
            bit  mute;
            int  lat;
            logic [6:0] vs [4];
            logic [6:0] ps [3];
            vs[0] = 7'h10; vs[1] = 7'h11; vs[2] = 7'h22; vs[3] = 7'h33;
            ps[0] = 7'h34; ps[1] = 7'h35; ps[2] = 7'h50;
            if ($urandom_range(0, 2) == 0) begin
                cfg_wr(int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                       vs[$urandom_range(0, 3)], ps[$urandom_range(0, 2)]);
            end
            a    = ($urandom_range(0, 4) == 4) ? 7'($urandom) : vs[$urandom_range(0, 3)];
            mute = ($urandom_range(0, 7) == 0);
            lat  = ($urandom_range(0, 9) == 0) ? 49 : int'($urandom_range(1, 6));
            run_txn(a, 1'($urandom), 8'($urandom), mute, lat, -1, 7'h00, r);
            chk_res($sformatf("rnd%0d", t), r, model(a, mute, lat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
